// File: rtl/sobol_stream_sched.sv
// Round-robin burst scheduler streaming samples from one shared Sobol generator.
// Build option SOBOL_SKIP_ZERO_EN: start the sequence at idx=1 so the all-zero point is skipped.
module sobol_stream_sched #(
  parameter logic [1023:0] DVA = {
    32'hFFFFFFFF, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'h88888888,
    32'hF0F0F0F0, 32'hA0A0A0A0, 32'hC0C0C0C0, 32'h80808080,
    32'hFF00FF00, 32'hAA00AA00, 32'hCC00CC00, 32'h88008800,
    32'hF000F000, 32'hA000A000, 32'hC000C000, 32'h80008000,
    32'hFFFF0000, 32'hAAAA0000, 32'hCCCC0000, 32'h88880000,
    32'hF0F00000, 32'hA0A00000, 32'hC0C00000, 32'h80800000,
    32'hFF000000, 32'hAA000000, 32'hCC000000, 32'h88000000,
    32'hF0000000, 32'hA0000000, 32'hC0000000, 32'h80000000
  },
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*LEN_W-1:0] req_len,
  input  logic               restart,
  output logic [3:0]         gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [1:0]         out_id,
  output logic               out_last,
  output logic               busy
);

`ifdef SOBOL_SKIP_ZERO_EN
  localparam logic [31:0] INIT_IDX = 32'd1;
  localparam logic [31:0] INIT_SMP = DVA[31:0];
`else
  localparam logic [31:0] INIT_IDX = '0;
  localparam logic [31:0] INIT_SMP = '0;
`endif

  localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [31:0]      idx_q, idx_d;
  logic [31:0]      smp_q, smp_d;
  logic [LEN_W:0]   rem_q, rem_d;
  logic [1:0]       id_q, id_d;
  logic [3:0]       gnt_q, gnt_d;

  logic             grant_any;
  logic [1:0]       grant_id;
  logic [1:0]       cand;
  logic [4:0]       kbit;
  logic [31:0]      dv_sel;
  logic [LEN_W-1:0] len_arr [4];
  logic [LEN_W-1:0] len_sel;

  // Scan offsets high to low so the offset closest to the pointer wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = rr_q;
    cand      = rr_q;
    for (int unsigned o = 4; o > 0; o--) begin
      cand = rr_q + 2'(o - 1);
      if (req[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // Lowest zero bit of idx; an all-ones idx leaves kbit at 0.
  always_comb begin
    kbit = '0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (!idx_q[i-1]) kbit = 5'(i - 1);
    end
    dv_sel = DVA[{kbit, 5'd0} +: 32];
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      len_arr[i] = req_len[i*LEN_W +: LEN_W];
    end
    len_sel = len_arr[grant_id];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= INIT_IDX;
      smp_q   <= INIT_SMP;
      rem_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      smp_q   <= smp_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    smp_d   = smp_q;
    rem_d   = rem_q;
    id_d    = id_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (restart) begin
          idx_d = INIT_IDX;
          smp_d = INIT_SMP;
        end
        if (grant_any) begin
          gnt_d   = 4'b0001 << grant_id;
          id_d    = grant_id;
          rr_d    = grant_id + 2'd1;
          rem_d   = (len_sel == '0) ? REM_FULL : {1'b0, len_sel};
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          idx_d = idx_q + 32'd1;
          smp_d = smp_q ^ dv_sel;
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == RUN);
    busy      = (state_q == RUN);
    out_last  = (rem_q == REM_ONE);
    gnt       = gnt_q;
    out_id    = id_q;
    out_data  = smp_q;
  end

endmodule

// File: tb/tb_sobol_stream_sched.sv
// Self-checking bench for sobol_stream_sched: directed vectors plus randomized traffic vs a transaction model.
`timescale 1ns/1ps
module tb_sobol_stream_sched;
  localparam int unsigned LEN_W = 8;
`ifdef SOBOL_SKIP_ZERO_EN
  localparam logic [31:0] N0 = 32'd1;
`else
  localparam logic [31:0] N0 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_len;
  logic        restart;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_id;
  logic        out_last;
  logic        busy;

  sobol_stream_sched #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .restart(restart),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s @%0t actual=%h required=%h", name, $time, act, exp);
    else n_pass++;
  endtask

  // Direction vector k: row k of Pascal's triangle mod 2, MSB-aligned.
  function automatic logic [31:0] dv(input int unsigned k);
    logic [31:0] v;
    v = '0;
    for (int unsigned j = 0; j <= k; j++) if ((j & k) == j) v[31-j] = 1'b1;
    return v;
  endfunction

  // Gray-code form of the n-th Sobol point.
  function automatic logic [31:0] sobol(input logic [31:0] n);
    logic [31:0] g, s;
    g = n ^ (n >> 1);
    s = '0;
    for (int unsigned k = 0; k < 32; k++) if (g[k]) s ^= dv(k);
    return s;
  endfunction

  // Transaction-level model state
  bit          m_run;
  int          m_rem, m_id, m_last;
  logic [3:0]  m_gnt;
  logic [31:0] m_n;
  logic [31:0] init_smp;
  int          hs_cnt, last_at, last_cnt;

  task automatic m_reset();
    m_run = 0; m_rem = 0; m_id = 0; m_last = 3; m_gnt = '0; m_n = N0;
  endtask

  task automatic m_step(input logic [3:0] r, input logic [31:0] lens, input logic rdy, input logic rs);
    int l;
    if (!m_run) begin
      m_gnt = '0;
      if (rs) m_n = N0;
      if (r != 4'd0) begin
        for (int o = 1; o <= 4; o++) begin
          int c;
          c = (m_last + o) % 4;
          if (r[c] && m_gnt == 4'd0) begin
            m_gnt = 4'b0001 << c;
            m_id  = c;
          end
        end
        m_last = m_id;
        m_run  = 1;
        l = int'(lens[m_id*LEN_W +: LEN_W]);
        m_rem = (l == 0) ? 256 : l;
      end
    end else begin
      m_gnt = '0;
      if (rdy) begin
        m_n++;
        m_rem--;
        if (m_rem == 0) m_run = 0;
      end
    end
  endtask

  // Compare this cycle's outputs with the model, then drive the next inputs.
  task automatic cyc(input logic [3:0] r, input logic [31:0] lens, input logic rdy, input logic rs);
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("out_valid", 32'(out_valid), 32'(m_run));
    chk("busy", 32'(busy), 32'(m_run));
    chk("out_data", out_data, sobol(m_n));
    chk("out_last", 32'(out_last), 32'(m_rem == 1));
    chk("out_id", 32'(out_id), 32'(m_id));
    if (out_valid && rdy) begin
      hs_cnt++;
      if (out_last) begin
        last_at = hs_cnt;
        last_cnt++;
      end
    end
    req = r; req_len = lens; out_ready = rdy; restart = rs;
    m_step(r, lens, rdy, rs);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_len = '0; restart = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", out_data, init_smp);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    hs_cnt = 0; last_at = 0; last_cnt = 0;
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [7:0]  len0;
    logic        rdy;
    logic [3:0]  egnt;
    logic        evld;
    logic [31:0] edat;
    logic        elast;
  } vec_t;

  vec_t tbl [7];
  logic [3:0] gq [$];
  logic [3:0] exp_order [5];
  logic       pat [5];

  initial begin
    init_smp = sobol(N0);
`ifdef SOBOL_SKIP_ZERO_EN
    tbl[0] = '{4'b0001, 8'd5, 1'b1, 4'b0001, 1'b1, 32'h80000000, 1'b0};
    tbl[1] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 32'h40000000, 1'b0};
    tbl[2] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 32'hC0000000, 1'b0};
    tbl[3] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 32'h60000000, 1'b0};
    tbl[4] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 32'hE0000000, 1'b1};
    tbl[5] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b0, 32'h20000000, 1'b0};
    tbl[6] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b0, 32'h20000000, 1'b0};
`else
    tbl[0] = '{4'b0001, 8'd5, 1'b1, 4'b0001, 1'b1, 32'h00000000, 1'b0};
    tbl[1] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 32'h80000000, 1'b0};
    tbl[2] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 32'h40000000, 1'b0};
    tbl[3] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 32'hC0000000, 1'b0};
    tbl[4] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b1, 32'h60000000, 1'b1};
    tbl[5] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b0, 32'hE0000000, 1'b0};
    tbl[6] = '{4'b0000, 8'd5, 1'b1, 4'b0000, 1'b0, 32'hE0000000, 1'b0};
`endif
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;

    // Single burst of five from requester 0
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].r; req_len = {24'd0, tbl[i].len0}; out_ready = tbl[i].rdy; restart = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].egnt));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].evld));
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].edat);
      chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].elast));
    end

    // All four requesting, length 1: round-robin rotation
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (gnt != 4'd0) gq.push_back(gnt);
      cyc(4'hF, 32'h01010101, 1'b1, 1'b0);
    end
    cyc(4'h0, 32'h01010101, 1'b1, 1'b0);
    chk("rr_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk($sformatf("rr_order%0d", i), 32'(gq[i]), 32'(exp_order[i]));

    // Length 3 with consumer stalls
    do_reset();
    cyc(4'b0001, 32'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(4'b0000, 32'd3, pat[i], 1'b0);
    cyc(4'b0000, 32'd3, 1'b0, 1'b0);
    chk("stall_handshakes", 32'(hs_cnt), 32'd3);
    chk("stall_last_at", 32'(last_at), 32'd3);
    chk("stall_idx", dut.idx_q, N0 + 32'd3);

    // Restart coinciding with a grant after four samples; restart during RUN ignored
    do_reset();
    cyc(4'b0001, 32'd4, 1'b1, 1'b0);
    repeat (4) cyc(4'b0000, 32'd4, 1'b1, 1'b0);
    chk("pre_restart_idx", dut.idx_q, N0 + 32'd4);
    cyc(4'b0001, 32'd3, 1'b1, 1'b1);
    chk("restart_first", out_data, init_smp);
    cyc(4'b0000, 32'd3, 1'b1, 1'b1);
    repeat (3) cyc(4'b0000, 32'd3, 1'b1, 1'b0);

    // Zero length means 2^LEN_W samples
    do_reset();
    cyc(4'b0001, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 262; i++) cyc(4'b0000, 32'd0, 1'b1, 1'b0);
    chk("len0_samples", 32'(hs_cnt), 32'd256);
    chk("len0_last_at", 32'(last_at), 32'd256);
    chk("len0_last_cnt", 32'(last_cnt), 32'd1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [31:0] lens;
      for (int q = 0; q < 4; q++) lens[q*8 +: 8] = 8'($urandom_range(1, 6));
      cyc(4'($urandom_range(0, 15)), lens, ($urandom % 4) != 0, ($urandom % 8) == 0);
    end

    // Index wrap, then asynchronous reset mid-burst
    do_reset();
    req = 4'b0001; req_len = 32'd3; out_ready = 1'b0; restart = 1'b0;
    @(negedge clk);
    req = 4'b0000;
    force dut.idx_q = 32'hFFFF_FFFF;
    force dut.smp_q = 32'h1234_5678;
    #1;
    release dut.idx_q;
    release dut.smp_q;
    #1;
    chk("wrap_pre_data", out_data, 32'h1234_5678);
    out_ready = 1'b1;
    @(negedge clk);
    chk("wrap_data", out_data, 32'h9234_5678);
    chk("wrap_idx", dut.idx_q, 32'd0);
    chk("wrap_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_data", out_data, init_smp);
    @(negedge clk);
    chk("reset_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    cyc(4'b0001, 32'd4, 1'b1, 1'b0);
    chk("post_reset_first", out_data, init_smp);
    repeat (6) cyc(4'b0000, 32'd4, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sobol_stream_sched.md
SOBOL_STREAM_SCHED -- requirements
Module: sobol_stream_sched

Interface
REQ-001 SHALL have parameter DVA, default = team standard 32x32 Sobol direction-vector table (DVA0 in bits [31:0]; DVA0=0x80000000, DVA1=0xC0000000, DVA2=0xA0000000), meaning per-bit XOR vectors.
REQ-002 SHALL have parameter LEN_W, default 8, meaning burst-length field width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req  in  4  per-requester burst request, level.
- req_len  in  4*LEN_W  requester i length in [i*LEN_W +: LEN_W].
- restart  in  1  pulse; rewinds the sequence.
- gnt  out  4  one-hot grant pulse.
- out_valid  out  1  sample valid.
- out_ready  in  1  consumer ready.
- out_data  out  32  Sobol sample.
- out_id  out  2  index of the owning requester.
- out_last  out  1  final sample of the burst.
- busy  out  1  FSM in RUN.

Function
REQ-005 SHALL hold the internal generator state as idx[31:0] and smp[31:0]; out_data = smp.
REQ-006 SHALL advance the generator only on an out_valid&out_ready handshake:
- smp <= smp ^ DVA[k], where k = position of the lowest zero bit of idx.
- idx <= idx+1.
REQ-007 When idx = 0xFFFFFFFF, SHALL use k=0 and wrap idx to 0.
REQ-008 SHALL implement FSM states IDLE and RUN.
REQ-009 In IDLE with any req bit set, SHALL grant one requester by round-robin:
- Search starts at (last granted+1) mod 4.
- Search starts at 0 after reset.
REQ-010 On a grant, SHALL:
- Pulse gnt[i] for exactly one cycle.
- Latch out_id=i.
- Latch remaining = req_len[i].
- Go to RUN on the next edge.
REQ-011 A req_len value of 0 SHALL mean 2^LEN_W samples.
REQ-012 In RUN, SHALL hold out_valid=1 and keep out_data, out_id and out_last stable until the handshake.
REQ-013 out_last SHALL be 1 exactly when remaining = 1.
REQ-014 Each handshake SHALL decrement remaining.
REQ-015 The handshake with out_last=1 SHALL return the FSM to IDLE, giving at least one idle cycle between bursts.
REQ-016 req changes during RUN SHALL be ignored; a burst is never pre-empted.
REQ-017 Generator state SHALL persist across bursts, so successive bursts continue one shared sequence.
REQ-018 restart in IDLE SHALL reload the generator initial state on the next edge.
REQ-019 restart in the same cycle as a grant SHALL make that burst's first sample the initial point.
REQ-020 restart in RUN SHALL be ignored.
REQ-021 busy SHALL be 1 exactly in RUN.

Reset
REQ-022 rst_n low SHALL immediately force:
- FSM = IDLE.
- gnt = 0, out_valid = 0, out_last = 0, out_id = 0.
- remaining = 0.
- round-robin pointer = 0.
- generator = initial state.
REQ-023 Reset mid-burst SHALL abandon the burst with no further samples emitted.

Configuration
REQ-024 Macro SOBOL_SKIP_ZERO_EN:
- Defined: generator initial state is idx=1, smp=DVA0 (first sample 0x80000000; the all-zero point is skipped).
- Undefined: initial state is idx=0, smp=0.

Verification
REQ-025 Macro undefined, req=0001, len0=5, out_ready=1 -> gnt=0001 for one cycle; out_data = 0, 0x80000000, 0x40000000, 0xC0000000, 0x60000000; out_last only on the fifth sample; then IDLE.
REQ-026 req=1111, all lengths 1, held -> grant order 0, 1, 2, 3, 0; out_id matches; one sample each; sequence continues across bursts.
REQ-027 len=3, out_ready toggles 1,0,0,1,1 -> out_data and out_last hold during stalls; exactly 3 handshakes; the generator advances 3 times.
REQ-028 restart with a simultaneous grant after 4 prior samples -> first sample 0 (or 0x80000000 with SOBOL_SKIP_ZERO_EN).
REQ-029 Force idx=0xFFFFFFFF, one handshake -> smp ^= DVA0 and idx = 0; rst_n low mid-burst -> out_valid drops asynchronously, and the next burst after reset starts at the initial point.
REQ-030 len=0 with LEN_W=8 -> 256 samples, out_last on the 256th.
